// File: rtl/qc_pkg.sv
// Shared definitions for the gate-program datapath.
//   NUMBER_BITS     default width of one signed fixed-point matrix cell
//   CELLS_PER_GATE  cells streamed per 2x2 complex gate matrix
//   REAL / IMAG     position of a cell inside a (row, col) pair
//   gate_seq_state_t  controller state encoding
package qc_pkg;

    localparam int NUMBER_BITS    = 37;
    localparam int CELLS_PER_GATE = 8;

    // Cells arrive row-major; within one matrix element the real part comes first.
    localparam int REAL = 0;
    localparam int IMAG = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_WAIT_DEC,
        ST_APPLY,
        ST_WAIT_APPLY,
        ST_FINISH
    } gate_seq_state_t;

endpackage

// File: rtl/gate_load_sequencer.sv
// Walks a program of gate_count gates. For every gate it clears the serial
// matrix decoder, streams exactly 8 cells into it, pulses the 2x2 apply unit
// and waits for that unit to finish.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   start, gate_count       begin a program (sampled in IDLE only)
//   src_data/valid/ready    valid/ready cell stream from the gate source
//   dec_reset               clear pulse to the decoder (also high during reset)
//   dec_cell, dec_ready     cell and write strobe to the decoder
//   dec_done                decoder holds all 8 cells
//   apply_start/apply_done  one-cycle start / completion (pulse or level)
//   gate_index, busy, done  progress, activity, one-cycle end-of-program
module gate_load_sequencer #(
    parameter int NUMBER_BITS = qc_pkg::NUMBER_BITS,
    parameter int GATE_BITS   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [GATE_BITS-1:0]          gate_count,
    input  logic signed [NUMBER_BITS-1:0] src_data,
    input  logic                          src_valid,
    output logic                          src_ready,
    output logic                          dec_reset,
    output logic signed [NUMBER_BITS-1:0] dec_cell,
    output logic                          dec_ready,
    input  logic                          dec_done,
    output logic                          apply_start,
    input  logic                          apply_done,
    output logic [GATE_BITS-1:0]          gate_index,
    output logic                          busy,
    output logic                          done
);
    import qc_pkg::*;

    localparam logic [3:0]           CELLS = 4'(CELLS_PER_GATE);
    localparam logic [3:0]           LAST_CELL = 4'(CELLS_PER_GATE - 1);
    localparam logic [GATE_BITS-1:0] ONE = GATE_BITS'(1);

    gate_seq_state_t        state_q, state_d;
    logic [3:0]             cell_cnt_q, cell_cnt_d;
    logic [GATE_BITS-1:0]   gate_index_q, gate_index_d;
    logic [GATE_BITS-1:0]   gate_count_q, gate_count_d;

    logic ready_int, clear_int, apply_int, done_int;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cell_cnt_q   <= '0;
            gate_index_q <= '0;
            gate_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cell_cnt_q   <= cell_cnt_d;
            gate_index_q <= gate_index_d;
            gate_count_q <= gate_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cell_cnt_d   = cell_cnt_q;
        gate_index_d = gate_index_q;
        gate_count_d = gate_count_q;
        ready_int    = 1'b0;
        clear_int    = 1'b0;
        apply_int    = 1'b0;
        done_int     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gate_index_d = '0;
                    if (gate_count != '0) begin
                        gate_count_d = gate_count;
                        state_d      = ST_CLEAR;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_CLEAR: begin
                clear_int  = 1'b1;
                cell_cnt_d = '0;
                state_d    = ST_LOAD;
            end
            ST_LOAD: begin
                // The count guard keeps a 9th cell from ever being accepted.
                ready_int = (cell_cnt_q < CELLS);
                if (src_valid && ready_int) begin
                    cell_cnt_d = cell_cnt_q + 4'd1;
                    if (cell_cnt_q == LAST_CELL) state_d = ST_WAIT_DEC;
                end
            end
            ST_WAIT_DEC: begin
                if (dec_done) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                apply_int = 1'b1;
                state_d   = ST_WAIT_APPLY;
            end
            ST_WAIT_APPLY: begin
                // A level-style apply_done is harmless: it is only looked at here,
                // and the next WAIT_APPLY is at least 11 cycles away.
                if (apply_done) begin
                    if (gate_index_q == gate_count_q - ONE) begin
                        state_d = ST_FINISH;
                    end else begin
                        gate_index_d = gate_index_q + ONE;
                        state_d      = ST_CLEAR;
                    end
                end
            end
            ST_FINISH: begin
                done_int = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are forced low while reset is held, because the state register
    // only clears on the next edge. The decoder clear is forced high instead so
    // an abandoned, partially loaded matrix is wiped.
    assign src_ready   = ready_int & ~reset;
    assign dec_ready   = src_valid & src_ready;
    assign dec_cell    = src_data;
    assign dec_reset   = reset | clear_int;
    assign apply_start = apply_int & ~reset;
    assign done        = done_int & ~reset;
    assign busy        = ~reset & (state_q != ST_IDLE);
    assign gate_index  = gate_index_q;

endmodule

// File: tb/tb_gate_load_sequencer.sv
module tb_gate_load_sequencer;
    import qc_pkg::*;

    localparam int NB = 37;
    localparam int GB = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [GB-1:0]        gate_count = '0;
    logic signed [NB-1:0] src_data = '0;
    logic                 src_valid = 1'b0;
    logic                 src_ready;
    logic                 dec_reset;
    logic signed [NB-1:0] dec_cell;
    logic                 dec_ready;
    logic                 dec_done;
    logic                 apply_start;
    logic                 apply_done = 1'b0;
    logic [GB-1:0]        gate_index;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    gate_load_sequencer #(.NUMBER_BITS(NB), .GATE_BITS(GB)) dut (
        .clk(clk), .reset(reset), .start(start), .gate_count(gate_count),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .dec_reset(dec_reset), .dec_cell(dec_cell), .dec_ready(dec_ready),
        .dec_done(dec_done), .apply_start(apply_start), .apply_done(apply_done),
        .gate_index(gate_index), .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cidx(input int r, input int c, input int part);
        return (r * 2 + c) * 2 + part;
    endfunction

    // ---------------- source: queue of cells, optional every-other-cycle valid
    logic signed [NB-1:0] src_q[$];
    bit toggle_mode = 1'b0;
    bit phase = 1'b0;

    initial forever begin
        bit hs;
        @(posedge clk);
        hs = src_valid && src_ready;
        #1;
        if (hs && src_q.size() > 0) void'(src_q.pop_front());
        phase = ~phase;
        src_valid = (src_q.size() > 0) && (!toggle_mode || phase);
        src_data  = (src_q.size() > 0) ? src_q[0] : '0;
    end

    // ---------------- decoder: 8-entry store, cleared by dec_reset
    logic signed [NB-1:0] dmat[8];
    int dcnt = 0;
    always @(posedge clk) begin
        if (dec_reset) dcnt <= 0;
        else if (dec_ready && dcnt < 8) begin
            dmat[dcnt[2:0]] <= dec_cell;
            dcnt <= dcnt + 1;
        end
    end
    assign dec_done = (dcnt == 8);

    // ---------------- apply unit: done one cycle after start, held apply_hold cycles
    int apply_hold = 1;
    initial forever begin
        @(posedge clk);
        if (apply_start && !reset) begin
            #1 apply_done = 1'b1;
            repeat (apply_hold) @(posedge clk);
            #1 apply_done = 1'b0;
        end
    end

    // ---------------- behavioural model of the program walk
    bit m_busy, m_pend, m_load;
    int m_cells, m_gi, m_gcount, m_next, m_cd;   // m_next: 1 expect clear, 2 expect done

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0; m_pend <= 0; m_load <= 0;
            m_cells <= 0; m_gi <= 0; m_next <= 0; m_cd <= 0;
        end else begin
            m_next <= 0;
            if (m_cd != 0) m_cd <= m_cd - 1;
            if (!m_busy && start) begin
                m_busy   <= 1;
                m_gcount <= int'(gate_count);
                m_gi     <= 0;
                m_next   <= (gate_count != 0) ? 1 : 2;
            end
            if (done) m_busy <= 0;
            if (dec_reset) begin
                m_cells <= 0;
                m_load  <= 1;
            end else if (dec_ready) begin
                m_cells <= m_cells + 1;
                if (m_cells == 7) begin
                    m_load <= 0;
                    m_cd   <= 2;   // one cycle waiting on the decoder, then apply
                end
            end
            if (apply_start) m_pend <= 1;
            if (m_pend && apply_done) begin
                m_pend <= 0;
                if (m_gi + 1 < m_gcount) begin
                    m_gi   <= m_gi + 1;
                    m_next <= 1;
                end else begin
                    m_next <= 2;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model
    bit chk_en = 1'b0;
    int hs_cnt = 0, ap_cnt = 0, done_cnt = 0;
    int ap_gi[$];

    always @(negedge clk) begin
        if (chk_en) begin
            if (reset) begin
                chk("rst_dec_reset", dec_reset, 1);
                chk("rst_src_ready", src_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_apply_start", apply_start, 0);
                chk("rst_done", done, 0);
            end else begin
                chk("busy", busy, m_busy);
                chk("done", done, m_next == 2);
                chk("dec_reset", dec_reset, m_next == 1);
                chk("src_ready", src_ready, m_load);
                chk("dec_ready", dec_ready, src_valid && src_ready);
                chk("dec_cell", dec_cell, src_data);
                chk("apply_start", apply_start, m_cd == 1);
                chk("gate_index", gate_index, m_gi);
                if (src_ready) chk("cells_below_8", m_cells < 8, 1);
                if (dec_ready) hs_cnt++;
                if (apply_start) begin
                    ap_cnt++;
                    ap_gi.push_back(int'(gate_index));
                end
                if (done) done_cnt++;
            end
        end
    end

    // ---------------- directed stimulus
    task automatic do_start(input int gc);
        @(posedge clk); #1;
        start = 1'b1;
        gate_count = GB'(gc);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int maxc, input string nm);
        int k = 0;
        while (done_cnt == d0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk(nm, done_cnt - d0, 1);
    endtask

    task automatic wait_hs(input int h0, input int n, input string nm);
        int k = 0;
        while (hs_cnt - h0 < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(nm, hs_cnt - h0, n);
    endtask

    initial begin
        logic [15:0] v_clr, v_rdy, v_ap, v_done;
        logic signed [NB-1:0] cells[$];
        int h0, a0, d0, g0;

        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_gate_index", gate_index, 0);
        chk("reset_busy", busy, 0);
        chk("reset_src_ready", src_ready, 0);

        // ---- 1 gate, identity, exact cycle timeline
        @(negedge clk);
        cells = '{1, 0, 0, 0, 0, 0, 1, 0};
        foreach (cells[i]) src_q.push_back(cells[i]);
        v_clr = '0; v_rdy = '0; v_ap = '0; v_done = '0;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; gate_count = 8'd1;          // cycle 0
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            v_clr[k]  = dec_reset;
            v_rdy[k]  = dec_ready;
            v_ap[k]   = apply_start;
            v_done[k] = done;
        end
        chk("t1_clear_cycle", v_clr, 16'h0002);
        chk("t1_strobe_cycles", v_rdy, 16'h03FC);
        chk("t1_apply_cycle", v_ap, 16'h0800);
        chk("t1_done_cycle", v_done, 16'h2000);
        chk("t1_m00_re", dmat[cidx(0, 0, REAL)], 1);
        chk("t1_m00_im", dmat[cidx(0, 0, IMAG)], 0);
        chk("t1_m11_re", dmat[cidx(1, 1, REAL)], 1);
        chk("t1_m01_re", dmat[cidx(0, 1, REAL)], 0);
        chk("t1_done_count", done_cnt - d0, 1);

        // ---- 3 gates, src_valid every other cycle
        @(negedge clk);
        toggle_mode = 1'b1;
        cells.delete();
        for (int i = 0; i < 24; i++) cells.push_back(NB'(i * 1000 - 7000));
        foreach (cells[i]) src_q.push_back(cells[i]);
        h0 = hs_cnt; a0 = ap_cnt; d0 = done_cnt; g0 = ap_gi.size();
        do_start(3);
        wait_done(d0, 300, "t2_done");
        chk("t2_handshakes", hs_cnt - h0, 24);
        chk("t2_applies", ap_cnt - a0, 3);
        for (int i = 0; i < 3; i++) chk("t2_apply_index", ap_gi[g0 + i], i);
        chk("t2_src_drained", src_q.size(), 0);
        chk("t2_last_cell", dmat[7], 16000);
        chk("t2_first_cell_g2", dmat[0], 9000);
        toggle_mode = 1'b0;

        // ---- zero gates
        repeat (2) @(negedge clk);
        h0 = hs_cnt; a0 = ap_cnt;
        @(posedge clk); #1;
        start = 1'b1; gate_count = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t3_done", done, 1);
        @(negedge clk);
        chk("t3_done_gone", done, 0);
        chk("t3_idle", busy, 0);
        chk("t3_no_strobe", hs_cnt - h0, 0);
        chk("t3_no_apply", ap_cnt - a0, 0);

        // ---- reset after the 5th cell of gate 0
        @(negedge clk);
        cells.delete();
        for (int i = 0; i < 8; i++) cells.push_back(NB'(500 + i));
        foreach (cells[i]) src_q.push_back(cells[i]);
        h0 = hs_cnt;
        do_start(1);
        wait_hs(h0, 5, "t4_five_cells");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t4_dec_reset_in_reset", dec_reset, 1);
        chk("t4_busy_in_reset", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t4_busy_after", busy, 0);
        chk("t4_decoder_cleared", dcnt, 0);
        src_q.delete();
        cells.delete();
        for (int i = 0; i < 8; i++) cells.push_back(NB'(-(i + 1) * 123));
        foreach (cells[i]) src_q.push_back(cells[i]);
        h0 = hs_cnt; d0 = done_cnt;
        do_start(1);
        wait_done(d0, 100, "t4_done");
        chk("t4_fresh_count", hs_cnt - h0, 8);
        for (int i = 0; i < 8; i++) chk("t4_fresh_cell", dmat[i], -(i + 1) * 123);

        // ---- 9th cell waiting, start while busy, apply_done held 5 cycles
        @(negedge clk);
        apply_hold = 5;
        cells.delete();
        for (int i = 0; i < 16; i++) cells.push_back(NB'(3 * i + 1));
        foreach (cells[i]) src_q.push_back(cells[i]);
        h0 = hs_cnt; a0 = ap_cnt; d0 = done_cnt; g0 = ap_gi.size();
        do_start(2);
        wait_hs(h0, 8, "t5_eight_cells");
        @(negedge clk);
        chk("t5_ninth_ready", src_ready, 0);
        chk("t5_ninth_valid", src_valid, 1);
        chk("t5_ninth_data", src_data, 25);
        do_start(5);
        wait_done(d0, 200, "t5_done");
        chk("t5_applies", ap_cnt - a0, 2);
        chk("t5_handshakes", hs_cnt - h0, 16);
        chk("t5_idx0", ap_gi[g0], 0);
        chk("t5_idx1", ap_gi[g0 + 1], 1);
        chk("t5_final_index", gate_index, 1);
        chk("t5_gate1_cell0", dmat[0], 25);
        repeat (6) @(negedge clk);
        apply_hold = 1;

        // ---- maximum gate count, no index wrap
        @(negedge clk);
        for (int i = 0; i < 255 * 8; i++) src_q.push_back(NB'(i - 1000));
        h0 = hs_cnt; a0 = ap_cnt; d0 = done_cnt;
        do_start(255);
        wait_done(d0, 4000, "t6_done");
        chk("t6_applies", ap_cnt - a0, 255);
        chk("t6_last_apply_index", ap_gi[ap_gi.size() - 1], 254);
        chk("t6_final_index", gate_index, 254);
        chk("t6_handshakes", hs_cnt - h0, 2040);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
